iir_out_decimator: RTL and testbench

Downstream stage of the biquad IIR filter. Samples the filter output `y` on every clock and discards the start-up transient after reset. It averages each block of 2^DECIM_LOG2 samples into one decimated sample and buffers the results in a small FIFO. The FIFO is drained by a valid/ready consumer; a sticky overflow flag reports dropped results.

---
 rtl/iir_out_decimator.sv | 87 ++++++++
 tb/tb_iir_out_decimator.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/iir_out_decimator.sv
// Output stage for the biquad IIR: drops the start-up transient, averages blocks of
// 2^DECIM_LOG2 samples and queues the results in a show-ahead FIFO with sticky overflow.
module iir_out_decimator #(
  parameter int DECIM_LOG2 = 2,
  parameter int FIFO_DEPTH = 8,
  parameter int WARMUP     = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [15:0]                 y,
  output logic [15:0]                 out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [$clog2(FIFO_DEPTH):0] count,
  output logic                        overflow,
  input  logic                        clr_ovf
);
  localparam int AW = 16 + DECIM_LOG2;
  localparam int PW = (DECIM_LOG2 > 0) ? DECIM_LOG2 : 1;
  localparam int WW = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
  localparam int QW = $clog2(FIFO_DEPTH);
  localparam logic [PW-1:0] LAST_PHASE = PW'((1 << DECIM_LOG2) - 1);
  localparam logic [QW:0]   FULL       = (QW + 1)'(FIFO_DEPTH);

  logic [WW-1:0]        warm;
  logic [PW-1:0]        phase;
  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] sum;
  logic [15:0]          result;
  logic                 accept;
  logic                 push_req;
  logic                 push;
  logic                 pop;
  logic [QW-1:0]        wr_ptr;
  logic [QW-1:0]        rd_ptr;
  logic [15:0]          mem [FIFO_DEPTH];

  assign accept   = (warm == '0);
  assign sum      = acc + AW'($signed(y));
  // Floor division by the block length; the mean of 16-bit samples always fits in 16 bits.
  assign result   = 16'(sum >>> DECIM_LOG2);
  assign push_req = accept && (phase == LAST_PHASE);
  assign pop      = out_valid && out_ready;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign push     = push_req && ((count != FULL) || pop);

  assign out_valid = (count != '0);
  assign out_data  = out_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      warm  <= WW'(WARMUP);
      phase <= '0;
      acc   <= '0;
    end else if (!accept) begin
      warm <= warm - 1'b1;
    end else if (phase == LAST_PHASE) begin
      phase <= '0;
      acc   <= '0;
    end else begin
      phase <= phase + 1'b1;
      acc   <= sum;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      // A drop in the same cycle as a clear leaves the flag set.
      if (push_req && !push) overflow <= 1'b1;
      else if (clr_ovf)      overflow <= 1'b0;
    end
  end

  // Storage needs no reset: the pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= result;
  end
endmodule

// File: tb/tb_iir_out_decimator.sv
// Randomized and directed bench for iir_out_decimator against a queue-based model of
// block averaging, warm-up and FIFO occupancy.
module tb_iir_out_decimator;
  localparam int D     = 2;
  localparam int DEPTH = 8;
  localparam int WARM  = 4;
  localparam int N     = 1 << D;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] y = '0;
  logic        out_ready = 1'b0;
  logic        clr_ovf = 1'b0;
  logic [15:0] out_data;
  logic        out_valid;
  logic [3:0]  count;
  logic        overflow;

  always #5 clk = ~clk;

  iir_out_decimator #(.DECIM_LOG2(D), .FIFO_DEPTH(DEPTH), .WARMUP(WARM)) dut (
    .clk(clk), .reset(reset), .y(y), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .count(count), .overflow(overflow), .clr_ovf(clr_ovf)
  );

  int n_checks = 0;
  int n_errors = 0;
  int fq[$];
  int blk[$];
  int warm_left;
  bit ovf_m;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int floor_avg(input int s);
    if (s >= 0) return s / N;
    return -((-s + N - 1) / N);
  endfunction

  task automatic model_reset();
    fq.delete();
    blk.delete();
    warm_left = WARM;
    ovf_m = 1'b0;
  endtask

  task automatic step();
    int s;
    int res;
    bit push_req;
    bit dropped;
    s = 0;
    res = 0;
    push_req = 1'b0;
    dropped = 1'b0;
    @(posedge clk);
    if (warm_left > 0) begin
      warm_left--;
    end else begin
      blk.push_back(int'($signed(y)));
      if (blk.size() == N) begin
        foreach (blk[i]) s += blk[i];
        res = floor_avg(s);
        push_req = 1'b1;
        blk.delete();
      end
    end
    if (fq.size() > 0 && out_ready) begin
      $display("pop data=%0d", fq[0]);
      void'(fq.pop_front());
    end
    if (push_req) begin
      if (fq.size() < DEPTH) fq.push_back(res);
      else dropped = 1'b1;
    end
    if (dropped) ovf_m = 1'b1;
    else if (clr_ovf) ovf_m = 1'b0;
    #1;
    check("valid", int'(out_valid), int'(fq.size() > 0));
    check("data", int'($signed(out_data)), (fq.size() > 0) ? fq[0] : 0);
    check("count", int'(count), fq.size());
    check("overflow", int'(overflow), int'(ovf_m));
  endtask

  task automatic align();
    for (int i = 0; i < N + WARM && (blk.size() != 0 || warm_left > 0); i++) step();
    check("align", int'(blk.size() == 0 && warm_left == 0), 1);
  endtask

  initial begin
    int seq2[8];
    int seq3[8];
    int head1;
    seq2 = '{1, 2, 3, 4, -1, -2, -3, -4};
    seq3 = '{32767, 32767, 32767, 32767, -32768, -32768, -32768, -32768};
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", int'(out_valid), 0);
    check("rst_data", int'(out_data), 0);
    check("rst_count", int'(count), 0);
    check("rst_overflow", int'(overflow), 0);
    reset = 1'b0;

    // Warm-up then constant input
    y = 16'd100;
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step();
      check("t1_novalid", int'(out_valid), 0);
    end
    step();
    check("t1_first_valid", int'(out_valid), 1);
    check("t1_first_data", int'($signed(out_data)), 100);
    repeat (12) step();

    // Floor averaging of mixed-sign blocks
    align();
    for (int i = 0; i < 8; i++) begin
      y = 16'(seq2[i]);
      step();
      if (i == 3) check("t2_pos", int'($signed(out_data)), 2);
      if (i == 7) check("t2_neg", int'($signed(out_data)), -3);
    end

    // Extremes do not wrap
    for (int i = 0; i < 8; i++) begin
      y = 16'(seq3[i]);
      step();
      if (i == 3) check("t3_max", int'($signed(out_data)), 32767);
      if (i == 7) check("t3_min", int'($signed(out_data)), -32768);
    end

    // Overflow with a stalled consumer
    y = 16'd5;
    step();
    out_ready = 1'b0;
    repeat (35) step();
    check("t4_full_count", int'(count), 8);
    check("t4_ovf_set", int'(overflow), 1);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("t4_drain_data", int'($signed(out_data)), 5);
      step();
    end
    check("t4_ovf_sticky", int'(overflow), 1);
    for (int i = 0; i < 40 && fq.size() != 0; i++) step();
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    check("t4_ovf_clear", int'(overflow), 0);

    // Full FIFO with simultaneous push and pop
    align();
    y = 16'($urandom);
    step();
    out_ready = 1'b0;
    for (int i = 0; i < 60 && !(fq.size() == DEPTH && blk.size() == N - 1); i++) begin
      y = 16'($urandom);
      step();
    end
    check("t5_setup", int'(fq.size() == DEPTH && blk.size() == N - 1), 1);
    head1 = fq[1];
    out_ready = 1'b1;
    y = 16'($urandom);
    step();
    check("t5_count_hold", int'(count), 8);
    check("t5_no_ovf", int'(overflow), 0);
    check("t5_new_head", int'($signed(out_data)), head1);
    for (int i = 0; i < 40 && fq.size() != 0; i++) begin
      y = 16'($urandom);
      step();
    end

    // Reset mid-block with entries queued
    out_ready = 1'b0;
    for (int i = 0; i < 40 && !(fq.size() == 3 && blk.size() == 2); i++) begin
      y = 16'($urandom);
      step();
    end
    check("t6_setup", int'(fq.size() == 3 && blk.size() == 2), 1);
    #2 reset = 1'b1;
    #1;
    check("t6_valid", int'(out_valid), 0);
    check("t6_data", int'(out_data), 0);
    check("t6_count", int'(count), 0);
    check("t6_overflow", int'(overflow), 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    out_ready = 1'b1;
    y = 16'd1000;
    repeat (WARM) step();
    y = 16'd7;
    repeat (N) step();
    check("t6_post_data", int'($signed(out_data)), 7);

    // Random soak with random consumer and clears
    for (int i = 0; i < 400; i++) begin
      y = 16'($urandom);
      out_ready = (i < 200) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 4) == 0);
      clr_ovf = ($urandom_range(0, 15) == 0);
      step();
    end
    clr_ovf = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
